// File: rtl/cluster_mem_responder_pkg.sv
// Shared types, constants and lane helpers for the cluster memory responder.
package cluster_mem_responder_pkg;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned LINE_BYTES = 16;
    localparam int unsigned LINE_W     = LINE_BYTES * 8;
    localparam int unsigned OFFS_W     = 4;
    localparam int unsigned TAG_W      = ADDR_W - OFFS_W;
    localparam int unsigned CTRL_W     = 3;

    // funct3 encodings shared with the core's load/store decode
    localparam logic [CTRL_W-1:0] F3_B  = 3'b000;
    localparam logic [CTRL_W-1:0] F3_H  = 3'b001;
    localparam logic [CTRL_W-1:0] F3_W  = 3'b010;
    localparam logic [CTRL_W-1:0] F3_BU = 3'b100;
    localparam logic [CTRL_W-1:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_e;

    // Access size from funct3; every unlisted code behaves as a word
    function automatic size_e access_size(input logic [CTRL_W-1:0] ctrl);
        size_e sz;
        case (ctrl)
            F3_B, F3_BU: sz = SZ_B;
            F3_H, F3_HU: sz = SZ_H;
            F3_W:        sz = SZ_W;
            default:     sz = SZ_W;
        endcase
        return sz;
    endfunction

    // Byte enables of an access within its 16-byte line
    function automatic logic [LINE_BYTES-1:0] byte_mask(input logic [CTRL_W-1:0] ctrl,
                                                        input logic [OFFS_W-1:0] offset);
        logic [LINE_BYTES-1:0] base;
        case (access_size(ctrl))
            SZ_B:    base = LINE_BYTES'(4'h1);
            SZ_H:    base = LINE_BYTES'(4'h3);
            default: base = LINE_BYTES'(4'hF);
        endcase
        return base << offset;
    endfunction

endpackage

// File: rtl/cluster_mem_responder_if.sv
// Cluster-side request/response bus plus the line backend handshake.
interface cluster_mem_responder_if;
    import cluster_mem_responder_pkg::*;

    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic [CTRL_W-1:0]     ctrl;
    logic                  re;
    logic                  we;
    logic                  iscode;
    logic                  flush;
    logic                  busy_c;
    logic [LINE_W-1:0]     insn_data;
    logic [LINE_W-1:0]     data_data;
    logic                  is_dram_data;
    logic                  err;
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [LINE_W-1:0]     mem_wdata;
    logic [LINE_BYTES-1:0] mem_wmask;
    logic                  mem_ack;
    logic [LINE_W-1:0]     mem_rdata;

    // Requester side: cluster plus backend completion
    modport master (
        output addr, wdata, ctrl, re, we, iscode, flush, mem_ack, mem_rdata,
        input  busy_c, insn_data, data_data, is_dram_data, err,
               mem_req, mem_we, mem_addr, mem_wdata, mem_wmask
    );

    // Responder side
    modport slave (
        input  addr, wdata, ctrl, re, we, iscode, flush, mem_ack, mem_rdata,
        output busy_c, insn_data, data_data, is_dram_data, err,
               mem_req, mem_we, mem_addr, mem_wdata, mem_wmask
    );

endinterface

// File: rtl/cluster_store_lane.sv
// Places a right-aligned store into its line byte lanes and flags misalignment.
module cluster_store_lane
    import cluster_mem_responder_pkg::*;
(
    input  logic [CTRL_W-1:0]     ctrl,
    input  logic [OFFS_W-1:0]     offset,
    input  logic [DATA_W-1:0]     wdata,
    output logic [LINE_BYTES-1:0] mask_c,
    output logic [LINE_W-1:0]     data_c,
    output logic                  misaligned_c
);

    // Lane replication and alignment check by access size
    always_comb begin
        mask_c       = byte_mask(ctrl, offset);
        data_c       = {4{wdata}};
        misaligned_c = 1'b0;
        case (access_size(ctrl))
            SZ_B: data_c = {16{wdata[7:0]}};
            SZ_H: begin
                data_c       = {8{wdata[15:0]}};
                misaligned_c = offset[0];
            end
            default: begin
                data_c       = {4{wdata}};
                misaligned_c = (offset[1:0] != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/cluster_mem_responder.sv
// Converts cluster word/sub-word requests into masked line transactions,
// with a one-entry read line buffer kept coherent with local stores.
module cluster_mem_responder
    import cluster_mem_responder_pkg::*;
#(
    parameter logic [ADDR_W-1:0] DRAM_BASE   = 32'h8000_0000,
    parameter logic [ADDR_W-1:0] DRAM_MASK   = 32'hF800_0000,
    parameter bit                LINE_BUF_EN = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    cluster_mem_responder_if.slave  bus
);

    state_e                state_q, state_d;
    logic [ADDR_W-1:0]     addr_q;
    logic                  iscode_q;
    logic                  we_q;
    logic                  buf_valid;
    logic [TAG_W-1:0]      buf_tag;
    logic [LINE_W-1:0]     buf_line;
    logic [LINE_W-1:0]     merged_c;
    logic [LINE_BYTES-1:0] lane_mask_c;
    logic [LINE_W-1:0]     lane_data_c;
    logic                  misaligned_c;
    logic                  req_c;
    logic                  rd_hit_c;

    function automatic logic in_dram(input logic [ADDR_W-1:0] a);
        return (a & DRAM_MASK) == DRAM_BASE;
    endfunction

    cluster_store_lane u_lane (
        .ctrl         (bus.ctrl),
        .offset       (bus.addr[OFFS_W-1:0]),
        .wdata        (bus.wdata),
        .mask_c       (lane_mask_c),
        .data_c       (lane_data_c),
        .misaligned_c (misaligned_c)
    );

    assign req_c    = bus.re | bus.we;
    assign rd_hit_c = LINE_BUF_EN && buf_valid && bus.re && !bus.we &&
                      (buf_tag == bus.addr[ADDR_W-1:OFFS_W]);

    // Buffered line with the in-flight store bytes applied
    always_comb begin
        merged_c = buf_line;
        for (int unsigned i = 0; i < LINE_BYTES; i++) begin
            if (bus.mem_wmask[i]) merged_c[8*i +: 8] = bus.mem_wdata[8*i +: 8];
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next state and combinational stall
    always_comb begin
        state_d    = state_q;
        bus.busy_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bus.busy_c = req_c;
                if (req_c) state_d = (misaligned_c || rd_hit_c) ? ST_DONE : ST_REQ;
            end
            ST_REQ: begin
                bus.busy_c = 1'b1;
                if (bus.mem_ack) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Request latch, backend outputs, line buffer and DONE-cycle returns
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q           <= '0;
            iscode_q         <= 1'b0;
            we_q             <= 1'b0;
            buf_valid        <= 1'b0;
            buf_tag          <= '0;
            buf_line         <= '0;
            bus.insn_data    <= '0;
            bus.data_data    <= '0;
            bus.is_dram_data <= 1'b0;
            bus.err          <= 1'b0;
            bus.mem_req      <= 1'b0;
            bus.mem_we       <= 1'b0;
            bus.mem_addr     <= '0;
            bus.mem_wdata    <= '0;
            bus.mem_wmask    <= '0;
        end else begin
            bus.err          <= 1'b0;
            bus.is_dram_data <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_c) begin
                        addr_q   <= bus.addr;
                        iscode_q <= bus.iscode;
                        we_q     <= bus.we;
                        if (misaligned_c) begin
                            bus.err          <= 1'b1;
                            bus.is_dram_data <= in_dram(bus.addr);
                        end else if (rd_hit_c) begin
                            bus.is_dram_data <= in_dram(bus.addr);
                            if (bus.iscode) bus.insn_data <= buf_line;
                            else            bus.data_data <= buf_line;
                        end else begin
                            bus.mem_req   <= 1'b1;
                            bus.mem_we    <= bus.we;
                            bus.mem_addr  <= {bus.addr[ADDR_W-1:OFFS_W], OFFS_W'(0)};
                            bus.mem_wmask <= bus.we ? lane_mask_c : '0;
                            bus.mem_wdata <= bus.we ? lane_data_c : '0;
                        end
                    end
                end
                ST_REQ: begin
                    if (bus.mem_ack) begin
                        bus.mem_req      <= 1'b0;
                        bus.mem_we       <= 1'b0;
                        bus.is_dram_data <= in_dram(addr_q);
                        if (!we_q) begin
                            if (iscode_q) bus.insn_data <= bus.mem_rdata;
                            else          bus.data_data <= bus.mem_rdata;
                            if (LINE_BUF_EN) begin
                                buf_valid <= 1'b1;
                                buf_tag   <= addr_q[ADDR_W-1:OFFS_W];
                                buf_line  <= bus.mem_rdata;
                            end
                        end else if (buf_valid && buf_tag == addr_q[ADDR_W-1:OFFS_W]) begin
                            buf_line <= merged_c;
                        end
                    end
                end
                default: ;
            endcase
            // Flush beats a same-cycle fill
            if (bus.flush) buf_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cluster_mem_responder.sv
// Scoreboard bench for cluster_mem_responder with a line-memory backend model.
module tb_cluster_mem_responder;

    typedef struct {
        logic [31:0]  addr;
        bit           wr;
        bit           err;
        bit           dram;
        bit           backend;
        logic [15:0]  mask;
        logic [127:0] wline;
        logic [127:0] ins;
        logic [127:0] dat;
        int           busy;
    } exp_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    exp_t         sb[$];
    logic [127:0] mem[logic [27:0]];
    bit           mb_valid;
    logic [27:0]  mb_tag;
    logic [127:0] m_ins;
    logic [127:0] m_dat;

    cluster_mem_responder_if bus ();

    cluster_mem_responder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] mem_get(input logic [27:0] t);
        if (mem.exists(t)) return mem[t];
        return {4{{4'h0, t} ^ 32'h5A5A_3C3C}};
    endfunction

    // Reference behaviour: computes the expected outcome and advances the model
    task automatic model_req(input logic [31:0] a, input logic [2:0] c, input bit rd, input bit wr,
                             input bit code, input logic [31:0] wd, input int dly,
                             input bit flush_ack, output exp_t e);
        int           sz;
        bit           misal;
        bit           rd_eff;
        bit           hit;
        logic [15:0]  base;
        logic [127:0] line;
        sz     = (c == 3'b000 || c == 3'b100) ? 1 : (c == 3'b001 || c == 3'b101) ? 2 : 4;
        misal  = (sz == 2 && a[0]) || (sz == 4 && a[1:0] != 2'b00);
        rd_eff = rd && !wr;
        hit    = rd_eff && !misal && mb_valid && mb_tag == a[31:4];
        base   = (sz == 1) ? 16'h0001 : (sz == 2) ? 16'h0003 : 16'h000F;
        e.addr    = a;
        e.wr      = wr;
        e.err     = misal;
        e.dram    = (a & 32'hF800_0000) == 32'h8000_0000;
        e.backend = !misal && !hit;
        e.mask    = wr ? base << a[3:0] : 16'h0;
        e.wline   = (sz == 1) ? {16{wd[7:0]}} : (sz == 2) ? {8{wd[15:0]}} : {4{wd}};
        e.busy    = e.backend ? 2 + dly : 1;
        line      = mem_get(a[31:4]);
        if (!misal && rd_eff) begin
            if (code) m_ins = line;
            else      m_dat = line;
            if (e.backend) begin
                mb_valid = 1'b1;
                mb_tag   = a[31:4];
            end
        end
        if (!misal && wr) begin
            for (int i = 0; i < 16; i++)
                if (e.mask[i]) line[8*i +: 8] = e.wline[8*i +: 8];
            mem[a[31:4]] = line;
        end
        if (e.backend && flush_ack) mb_valid = 1'b0;
        e.ins = m_ins;
        e.dat = m_dat;
    endtask

    // Issue one request, serve the backend, and score the DONE cycle
    task automatic run_req(input logic [31:0] a, input logic [2:0] c, input bit rd, input bit wr,
                           input bit code, input logic [31:0] wd, input int dly, input bit flush_ack);
        exp_t e;
        exp_t g;
        int   busy_n;
        int   req_n;
        int   k;
        bit   done;
        bit   saw_req;
        model_req(a, c, rd, wr, code, wd, dly, flush_ack, e);
        sb.push_back(e);
        @(negedge clk);
        bus.addr = a; bus.ctrl = c; bus.re = rd; bus.we = wr; bus.iscode = code; bus.wdata = wd;
        #1;
        busy_n = 0; req_n = 0; k = 0; done = 1'b0; saw_req = 1'b0;
        while (!done && k < 64) begin
            if (bus.mem_req) begin
                if (!saw_req) begin
                    check_val("mem_addr", bus.mem_addr, {a[31:4], 4'h0});
                    check_val("mem_we", bus.mem_we, wr);
                    check_val("mem_wmask", bus.mem_wmask, e.mask);
                    if (wr) check_val("mem_wdata", bus.mem_wdata, e.wline);
                end
                saw_req = 1'b1;
                if (req_n == dly) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = mem_get(a[31:4]);
                    bus.flush     = flush_ack;
                end
                req_n++;
            end
            if (!bus.busy_c) done = 1'b1;
            else begin
                busy_n++;
                @(posedge clk); #1;
                bus.re = 1'b0; bus.we = 1'b0; bus.mem_ack = 1'b0; bus.flush = 1'b0;
                @(negedge clk); #1;
            end
            k++;
        end
        check_val("done_reached", done, 1'b1);
        if (sb.size() > 0) begin
            g = sb.pop_front();
            check_val("busy_cycles", 128'(busy_n), 128'(g.busy));
            check_val("backend_access", saw_req, g.backend);
            check_val("err", bus.err, g.err);
            check_val("is_dram_data", bus.is_dram_data, g.dram);
            check_val("insn_data", bus.insn_data, g.ins);
            check_val("data_data", bus.data_data, g.dat);
        end
        @(posedge clk); #1;
        bus.re = 1'b0; bus.we = 1'b0; bus.mem_ack = 1'b0; bus.flush = 1'b0;
        @(negedge clk); #1;
        check_val("err_after_done", bus.err, 1'b0);
    endtask

    initial begin
        logic [31:0] ra;
        clk = 1'b0; rst = 1'b0; n_cmp = 0; n_err = 0;
        bus.addr = '0; bus.wdata = '0; bus.ctrl = '0; bus.re = 1'b0; bus.we = 1'b0;
        bus.iscode = 1'b0; bus.flush = 1'b0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        mb_valid = 1'b0; mb_tag = '0; m_ins = '0; m_dat = '0;
        mem[28'h8000001] = {16{8'hA5}};

        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        check_val("rst_busy", bus.busy_c, 1'b0);
        check_val("rst_mem_req", bus.mem_req, 1'b0);
        check_val("rst_err", bus.err, 1'b0);
        check_val("rst_insn", bus.insn_data, 128'h0);
        check_val("rst_data", bus.data_data, 128'h0);
        check_val("rst_dram", bus.is_dram_data, 1'b0);
        rst = 1'b0;

        run_req(32'h8000_0010, 3'b010, 1, 0, 0, 32'h0, 3, 0);           // LW miss, busy 5
        check_val("lw_a5_line", bus.data_data, {16{8'hA5}});
        run_req(32'h8000_0014, 3'b010, 1, 0, 1, 32'h0, 0, 0);           // fetch hit
        run_req(32'h8000_0016, 3'b001, 0, 1, 0, 32'h0000_1234, 1, 0);   // SH, mask 00C0
        run_req(32'h8000_0010, 3'b010, 1, 0, 0, 32'h0, 0, 0);           // hit, merged line
        check_val("sh_merge_bytes", bus.data_data[63:48], 16'h1234);
        run_req(32'h8000_0002, 3'b010, 0, 1, 0, 32'h1111_2222, 0, 0);   // misaligned SW
        run_req(32'h8000_0023, 3'b000, 0, 1, 0, 32'h0000_00AB, 0, 0);   // SB other line
        run_req(32'h8000_0048, 3'b111, 0, 1, 0, 32'hCAFE_F00D, 1, 0);   // ctrl 111 as SW
        run_req(32'h8000_0010, 3'b100, 1, 0, 0, 32'h0, 0, 0);           // LBU still hits
        run_req(32'h1000_0000, 3'b100, 1, 0, 0, 32'h0, 2, 0);           // non-DRAM miss
        run_req(32'h1000_0001, 3'b101, 1, 0, 0, 32'h0, 0, 0);           // misaligned LHU
        run_req(32'h1000_0002, 3'b001, 1, 0, 1, 32'h0, 0, 0);           // LH hit
        run_req(32'h1000_0004, 3'b010, 1, 1, 0, 32'hDEAD_BEEF, 0, 0);   // write wins
        run_req(32'h1000_0000, 3'b010, 1, 0, 0, 32'h0, 0, 0);           // hit sees store
        run_req(32'h8000_0040, 3'b010, 1, 0, 0, 32'h0, 2, 1);           // fill + flush
        run_req(32'h8000_0040, 3'b010, 1, 0, 0, 32'h0, 0, 0);           // must miss

        // Reset mid-REQ, then a stray ack in IDLE
        @(negedge clk);
        bus.addr = 32'h8000_0100; bus.ctrl = 3'b010; bus.re = 1'b1; bus.iscode = 1'b0;
        @(posedge clk); #1 bus.re = 1'b0;
        @(negedge clk); #1;
        check_val("rst_req_up", bus.mem_req, 1'b1);
        rst = 1'b1; #1;
        check_val("rst_req_drop", bus.mem_req, 1'b0);
        check_val("rst_req_busy", bus.busy_c, 1'b0);
        check_val("rst_req_data", bus.data_data, 128'h0);
        check_val("rst_req_insn", bus.insn_data, 128'h0);
        mb_valid = 1'b0; m_ins = '0; m_dat = '0;
        @(negedge clk) rst = 1'b0;
        bus.mem_ack = 1'b1; bus.mem_rdata = {8{16'hBAD0}};
        @(posedge clk); #1 bus.mem_ack = 1'b0;
        @(negedge clk); #1;
        check_val("stray_ack_req", bus.mem_req, 1'b0);
        check_val("stray_ack_busy", bus.busy_c, 1'b0);
        check_val("stray_ack_data", bus.data_data, 128'h0);
        run_req(32'h8000_0010, 3'b010, 1, 0, 0, 32'h0, 0, 0);           // fresh miss

        // Idle flush then miss, then hit
        @(negedge clk) bus.flush = 1'b1;
        @(posedge clk); #1 bus.flush = 1'b0;
        mb_valid = 1'b0;
        run_req(32'h8000_0010, 3'b010, 1, 0, 0, 32'h0, 1, 0);
        run_req(32'h8000_0018, 3'b010, 1, 0, 1, 32'h0, 0, 0);
        run_req(32'h1000_0000, 3'b010, 1, 0, 0, 32'h0, 0, 0);

        for (int n = 0; n < 24; n++) begin
            bit wr;
            bit rd;
            case ($urandom_range(0, 2))
                0:       ra = 32'h8000_0000;
                1:       ra = 32'h8000_0010;
                default: ra = 32'h1000_0020;
            endcase
            ra = ra | 32'($urandom_range(0, 15));
            wr = ($urandom_range(0, 2) == 0);
            rd = !wr || ($urandom_range(0, 1) == 1);
            run_req(ra, 3'($urandom_range(0, 7)), rd, wr, rd && !wr && ($urandom_range(0, 1) == 1),
                    $urandom, $urandom_range(0, 3), ($urandom_range(0, 5) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cluster_mem_responder.md
Name: cluster_mem_responder

Overview:
- Responder end of the cluster memory request interface. Accepts the selected hart's fetch, load and store requests (address, funct3 ctrl, read enable, write enable, write data) and drives the busy and 128-bit line-data returns.
- Sits between the cluster and the DRAM/line backend.
- Turns word and sub-word requests into 16-byte line transactions with byte masks.
- Keeps a one-entry line buffer so repeated reads to the same line return without a backend access.

Parameters:
- DRAM_BASE, 32'h8000_0000: base address of the DRAM window.
- DRAM_MASK, 32'hF800_0000: an address is in DRAM when (addr & DRAM_MASK) == DRAM_BASE.
- LINE_BUF_EN, 1: 1 enables the one-entry read line buffer; 0 sends every read to the backend.

Ports:
- CLK  in  1  clock
- RST  in  1  asynchronous, active-high reset
- i_addr  in  32  request byte address
- i_wdata  in  32  store data, right-aligned
- i_ctrl  in  3  funct3 code: LB 000, LH 001, LW 010, LBU 100, LHU 101; for stores: SB 000, SH 001, SW 010
- i_re  in  1  read request (fetch or load)
- i_we  in  1  write request
- i_iscode  in  1  request is an instruction fetch
- i_flush  in  1  invalidate the line buffer
- o_busy  out  1  stall to the cluster
- o_insn_data  out  128  fetched line
- o_data_data  out  128  load line
- o_is_dram_data  out  1  returned line came from the DRAM window
- o_err  out  1  one-cycle pulse on a misaligned access
- o_mem_req  out  1  backend request, held until ack
- o_mem_we  out  1  backend write
- o_mem_addr  out  32  line address, {i_addr[31:4], 4'b0}
- o_mem_wdata  out  128  store data replicated into the byte lanes
- o_mem_wmask  out  16  byte enables
- i_mem_ack  in  1  backend completion, one cycle
- i_mem_rdata  in  128  backend line, valid with i_mem_ack

Behaviour:
- Reset (asynchronous, active-high): state IDLE, line buffer invalid, all outputs 0 (o_busy 0).
- States: IDLE, REQ, DONE.
- IDLE:
  - If i_re or i_we is high, latch addr, ctrl, wdata, iscode and we.
  - o_busy = 1 combinationally in this same cycle.
  - If both i_re and i_we are high, the write wins.
- IDLE routing:
  - Misaligned access (halfword with addr[0]=1, word with addr[1:0]!=0): go to DONE with o_err=1 and no backend access.
  - Read that hits the valid buffer (same line tag): go to DONE.
  - Any other request: go to REQ.
- REQ:
  - o_mem_req = 1, with address, mask and data stable until i_mem_ack.
  - On i_mem_ack: capture i_mem_rdata for a read; go to DONE.
- DONE (exactly one cycle):
  - o_busy = 0.
  - Fetch: o_insn_data = line. Load: o_data_data = line.
  - o_is_dram_data = DRAM window match of the latched address.
  - Then return to IDLE. A new request arriving in this cycle is not accepted until the next cycle.
- Write mask and data:
  - SB: mask = 1 << addr[3:0]; data = 16 copies of wdata[7:0].
  - SH: mask = 3 << addr[3:0]; data = 8 copies of wdata[15:0].
  - SW: mask = 15 << addr[3:0]; data = 4 copies of wdata.
  - ctrl values 011, 110 and 111 are treated as SW.
- Line buffer:
  - Filled on every completed backend read.
  - On a write to the buffered line, the buffer is merged byte-wise with the store at ack, so it stays coherent.
  - i_flush invalidates it in the cycle after assertion. A flush coinciding with a fill leaves the buffer invalid.
- Latency: buffer hit 2 cycles to busy low; backend access 3 + backend wait cycles.
- o_insn_data and o_data_data hold their last value outside DONE.
- Reset during REQ: o_mem_req drops immediately; a late i_mem_ack seen in IDLE is ignored.
- i_mem_ack outside REQ: ignored.

Decomposition:
- Shared package holds:
  - state encodings;
  - funct3 constants (shared with the core's FUNCT3 definitions);
  - the LINE_BYTES=16 constant;
  - a byte-mask function.
- One sub-module: cluster_store_lane, purely combinational (ctrl, addr[3:0], wdata) -> (mask, replicated data, misaligned). It is reused for the buffer merge.

Test Plan:
- LW read at 0x8000_0010; backend acks after 3 cycles with 128'hA5.. -> o_mem_addr=0x8000_0010; o_busy high 5 cycles; o_data_data=A5..; o_is_dram_data=1.
- Second fetch at 0x8000_0014 (same line) -> no o_mem_req; o_insn_data equals the buffered line 2 cycles after the request.
- SH at 0x8000_0016, wdata=0x1234 -> o_mem_wmask=16'h00C0; subsequent read of the line returns bytes 6..7 = 34,12 with no backend access.
- SW at 0x8000_0002 -> o_err pulses for one cycle; o_mem_req never rises; busy low after 2 cycles.
- Assert RST while in REQ, then pulse i_mem_ack -> outputs return to 0; state IDLE; ack ignored; next request is a fresh backend read.
- Pulse i_flush, then read 0x8000_0010 -> backend request issued (miss); read of 0x1000_0000 -> o_is_dram_data=0.
